// File: rtl/alu_lockstep_bist_if.sv
// Handshake and vector bus between the lockstep BIST controller and the dual ALU / host.
// The slave modport is the BIST controller's view; master is the host/ALU side.
interface alu_lockstep_bist_if;
    logic       start;
    logic       inject;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [1:0] alu_sel1;
    logic [1:0] alu_sel2;
    logic [7:0] x;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_idx;
    logic       first_fail_valid;

    modport slave (
        input  start, inject, x, y,
        output a0, b0, a1, b1, alu_sel1, alu_sel2,
        output busy, done, pass, err_count, first_fail_idx, first_fail_valid
    );

    modport master (
        output start, inject, x, y,
        input  a0, b0, a1, b1, alu_sel1, alu_sel2,
        input  busy, done, pass, err_count, first_fail_idx, first_fail_valid
    );
endinterface

// File: rtl/alu_lockstep_bist.sv
// Built-in self test for a lockstep dual ALU: walks 16 fixed vectors through both lanes and
// counts vectors whose lane outputs disagree (nonzero XOR or carry mismatch).
module alu_lockstep_bist #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_lockstep_bist_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_t;

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       inj;
    logic [7:0] a0_r, b0_r, a1_r, b1_r;
    logic [1:0] sel1_r, sel2_r;
    logic       busy_r, done_r, pass_r, ffv_r;
    logic [4:0] err_r;
    logic [3:0] ffi_r;

    logic [7:0] vec_a, vec_b;
    logic       mismatch;

    always_comb begin
        vec_a = 8'h00;
        vec_b = 8'h00;
        case (idx[1:0])
            2'd0: begin vec_a = 8'h00; vec_b = 8'h00; end
            2'd1: begin vec_a = 8'h81; vec_b = 8'h81; end
            2'd2: begin vec_a = 8'hFF; vec_b = 8'h01; end
            default: begin vec_a = 8'h55; vec_b = 8'hAA; end
        endcase
    end

    assign mismatch = (bus.x != 8'h00) || bus.y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            idx    <= '0;
            cnt    <= '0;
            inj    <= 1'b0;
            a0_r   <= '0;
            b0_r   <= '0;
            a1_r   <= '0;
            b1_r   <= '0;
            sel1_r <= '0;
            sel2_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= '0;
            ffi_r  <= '0;
            ffv_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        err_r  <= '0;
                        ffv_r  <= 1'b0;
                        ffi_r  <= '0;
                        pass_r <= 1'b0;
                        inj    <= bus.inject;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= StDrive;
                    end
                end
                StDrive: begin
                    a0_r   <= vec_a;
                    a1_r   <= vec_a;
                    b0_r   <= vec_b;
                    b1_r   <= vec_b ^ {7'b0, inj};
                    sel1_r <= idx[3:2];
                    sel2_r <= idx[3:2];
                    cnt    <= SettleCnt;
                    state  <= StWait;
                end
                StWait: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_r <= err_r + 5'd1;
                        if (!ffv_r) begin
                            ffi_r <= idx;
                            ffv_r <= 1'b1;
                        end
                    end
                    if (idx == 4'd15) begin
                        // pass is resolved here so it is valid alongside the done pulse
                        pass_r <= (err_r == 5'd0) && !mismatch;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= StDone;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= StDrive;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.a0               = a0_r;
    assign bus.b0               = b0_r;
    assign bus.a1               = a1_r;
    assign bus.b1               = b1_r;
    assign bus.alu_sel1         = sel1_r;
    assign bus.alu_sel2         = sel2_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.pass             = pass_r;
    assign bus.err_count        = err_r;
    assign bus.first_fail_idx   = ffi_r;
    assign bus.first_fail_valid = ffv_r;

endmodule

// File: tb/tb_alu_lockstep_bist.sv
// Randomized bench for alu_lockstep_bist against a run-level reference model of the 16-vector
// self test, with ideal, real dual-ALU and single-vector-fault ALU models on the bus.
module tb_alu_lockstep_bist;

    localparam int Settle = 2;
    localparam int Per    = Settle + 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   mode;
    int   mode1;

    logic [7:0] pa [4] = '{8'h00, 8'h81, 8'hFF, 8'h55};
    logic [7:0] pb [4] = '{8'h00, 8'h81, 8'h01, 8'hAA};

    alu_lockstep_bist_if bus ();
    alu_lockstep_bist_if bus1 ();

    alu_lockstep_bist #(.SETTLE(Settle)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_lockstep_bist #(.SETTLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Mode 0: ideal lanes, 1: real dual ALU, 2: carry flag forced only on vector 9 (op and, 81/81)
    logic [8:0] r1, r2, s1, s2;
    always_comb begin
        r1    = alu(bus.a0, bus.b0, bus.alu_sel1);
        r2    = alu(bus.a1, bus.b1, bus.alu_sel2);
        bus.x = 8'h00;
        bus.y = 1'b0;
        if (mode == 1) begin
            bus.x = r1[7:0] ^ r2[7:0];
            bus.y = r1[8] ^ r2[8];
        end else if (mode == 2) begin
            bus.y = (bus.alu_sel1 == 2'd2) && (bus.a0 == 8'h81);
        end
    end

    always_comb begin
        s1     = alu(bus1.a0, bus1.b0, bus1.alu_sel1);
        s2     = alu(bus1.a1, bus1.b1, bus1.alu_sel2);
        bus1.x = 8'h00;
        bus1.y = 1'b0;
        if (mode1 == 1) begin
            bus1.x = s1[7:0] ^ s2[7:0];
            bus1.y = s1[8] ^ s2[8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input int md, input logic inj, output int errs, output int ffi,
                         output logic ffv);
        logic [7:0] a, b;
        logic [1:0] op;
        logic       mism;
        errs = 0;
        ffi  = 0;
        ffv  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a    = pa[i % 4];
            b    = pb[i % 4];
            op   = 2'(i / 4);
            mism = 1'b0;
            if (md == 1) mism = alu(a, b, op) != alu(a, b ^ {7'b0, inj}, op);
            else if (md == 2) mism = (i == 9);
            if (mism) begin
                errs++;
                if (!ffv) begin
                    ffi = i;
                    ffv = 1'b1;
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bus.a0, bus.b0, bus.a1, bus.b1, bus.alu_sel1, bus.alu_sel2, bus.busy,
                    bus.done, bus.pass, bus.err_count, bus.first_fail_idx,
                    bus.first_fail_valid}, 64'd0);
    endtask

    task automatic run_check(input int md, input logic inj, input int poke);
        int         errs, ffi, busy_n, done_n, done_at, v;
        logic       ffv;
        logic [1:0] op;
        mode = md;
        model(md, inj, errs, ffi, ffv);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.inject = inj;
        for (int c = 1; c <= 16 * Per + 16; c++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = c;
                    check("pass", bus.pass, (errs == 0));
                    check("err_count", bus.err_count, errs);
                    check("first_fail_valid", bus.first_fail_valid, ffv);
                    check("first_fail_idx", bus.first_fail_idx, ffi);
                end
            end
            if (c % Per == 0 && c <= 16 * Per) begin
                v  = c / Per - 1;
                op = 2'(v / 4);
                check($sformatf("vector%0d", v),
                      {bus.a0, bus.b0, bus.a1, bus.b1, bus.alu_sel1, bus.alu_sel2},
                      {pa[v % 4], pb[v % 4], pa[v % 4], pb[v % 4] ^ {7'b0, inj}, op, op});
            end
            if (c == 1) bus.start = 1'b0;
            if (poke != 0 && c == poke) bus.start = 1'b1;
            if (poke != 0 && c == poke + 1) bus.start = 1'b0;
        end
        check("busy_cycles", busy_n, 16 * Per);
        check("done_cycle", done_at, 16 * Per + 1);
        check("done_pulses", done_n, 1);
    endtask

    initial begin
        int   done_seen, pulses, last_at;
        clk         = 1'b0;
        rst_n       = 1'b0;
        checks      = 0;
        errors      = 0;
        mode        = 0;
        mode1       = 1;
        bus.start   = 1'b0;
        bus.inject  = 1'b0;
        bus1.start  = 1'b0;
        bus1.inject = 1'b0;
        #3;
        check_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_check(0, 1'b0, 0);
        run_check(1, 1'b1, 0);
        run_check(1, 1'b0, 0);
        run_check(2, 1'b0, 0);
        run_check(0, 1'b0, 20);

        // Abort during vector 5 with an asynchronous reset between clock edges
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 5 * Per + 2; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrun_reset_outputs");
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);

        for (int r = 0; r < 5; r++) begin
            run_check(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 60)) : 0);
        end

        // SETTLE=1 instance with start held: back-to-back runs every 50 cycles
        @(negedge clk);
        bus1.start  = 1'b1;
        bus1.inject = 1'b1;
        pulses  = 0;
        last_at = 0;
        for (int c = 1; c <= 400 && pulses < 3; c++) begin
            @(negedge clk);
            if (bus1.done) begin
                if (pulses > 0) check("held_period", c - last_at, 50);
                check("held_err_count", bus1.err_count, 12);
                check("held_pass", bus1.pass, 1'b0);
                check("held_ffi", {bus1.first_fail_valid, bus1.first_fail_idx}, 5'h10);
                last_at = c;
                pulses++;
            end
        end
        check("held_pulses", pulses, 3);
        bus1.start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
